// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver, MSB first.
// Oversampled in the clk domain, words delivered through a FWFT FIFO.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          cs,
  input  logic                          mosi,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   cs_q;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   cs_fall;
  logic                   cs_rise;

  state_t                 state;
  state_t                 state_nx;
  logic [DATA_W-1:0]      shift;
  logic [DATA_W-1:0]      shift_nx;
  logic [BW-1:0]          bit_cnt;
  logic [BW-1:0]          bit_cnt_nx;
  logic                   ferr_nx;
  logic                   push;
  logic [DATA_W-1:0]      push_word;

  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   pop;
  logic                   wr_en;

  // Synchronizers reset to the bus idle levels
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign push_word = {shift[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      shift     <= shift_nx;
      bit_cnt   <= bit_cnt_nx;
      frame_err <= ferr_nx;
      overrun   <= push & full & ~pop;
    end
  end

  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_cnt_nx = bit_cnt;
    ferr_nx    = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        bit_cnt_nx = '0;
        if (cs_fall) begin
          state_nx = RECV;
          shift_nx = '0;
        end
      end
      RECV: begin
        // cs_rise wins over a coincident sclk edge
        if (cs_rise) begin
          state_nx   = IDLE;
          bit_cnt_nx = '0;
          ferr_nx    = (bit_cnt != '0);
        end else if (sclk_rise) begin
          shift_nx = push_word;
          if (bit_cnt == BW'(DATA_W - 1)) begin
            push       = 1'b1;
            bit_cnt_nx = '0;
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RECV);

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = out_valid & out_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: vector table, directed corner sequences,
// and random frames scored against a word-queue model.
module tb_spi_slave_rx;

  localparam int DW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          cs = 1'b1;
  logic          mosi = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [2:0]    fifo_count;
  logic          busy;
  logic          frame_err;
  logic          overrun;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(2), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int fe_cnt = 0, fe_hi = 0, ov_cnt = 0, ov_hi = 0;
  int exp_fe = 0, exp_ov = 0;
  logic fe_p = 1'b0, ov_p = 1'b0;
  logic hold_p = 1'b0;
  logic [7:0] hold_d = '0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [31:0] bits;
    int          nb;
    logic [2:0]  cnt;
    logic [7:0]  head;
    int          fe;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pulse counting, head stability, in-order pop scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_hi++;
      if (frame_err && !fe_p) fe_cnt++;
      if (overrun) ov_hi++;
      if (overrun && !ov_p) ov_cnt++;
      if (hold_p) chk("head_hold", out_data, hold_d);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_extra: got %0h expected no word", out_data);
        end else begin
          chk("pop_data", out_data, exp_q.pop_front());
        end
      end
      hold_p = out_valid && !out_ready;
      hold_d = out_data;
    end else begin
      hold_p = 1'b0;
    end
    fe_p = frame_err;
    ov_p = overrun;
  end

  function automatic void model_push(input logic [7:0] w, input bit allow);
    if (!allow && exp_q.size() >= FD) exp_ov++;
    else exp_q.push_back(w);
  endfunction

  task automatic sbit(input logic b);
    mosi = b;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    repeat (4) @(posedge clk);
    #1 sclk = 1'b1;
    repeat (4) @(posedge clk);
    #1 sclk = 1'b0;
  endtask

  task automatic frame(input logic [31:0] bits, input int nb,
                       input bit allow, input bit close);
    logic [7:0] w;
    w = '0;
    @(posedge clk);
    #1 cs = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) chk("busy_recv", busy, 1);
    for (int i = 0; i < nb; i++) begin
      w = {w[6:0], bits[nb-1-i]};
      if ((i + 1) % 8 == 0) model_push(w, allow);
      sbit(bits[nb-1-i]);
    end
    if (close) begin
      repeat (4) @(posedge clk);
      #1 cs = 1'b1;
      if (nb % 8 != 0) exp_fe++;
      repeat (8) @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    while (fifo_count != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got count %0d expected 0", fifo_count);
    end
    @(negedge clk);
    chk("drain_model_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int f0, o0;
    logic [7:0] w5;
    tbl[0] = '{32'hA3,    8,  3'd1, 8'hA3, 0};
    tbl[1] = '{32'h5AC3,  16, 3'd2, 8'h5A, 0};
    tbl[2] = '{32'b10110, 5,  3'd0, 8'h00, 1};
    tbl[3] = '{32'h81,    8,  3'd1, 8'h81, 0};
    tbl[4] = '{32'h12345, 20, 3'd2, 8'h12, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs",
        {out_valid, out_data, fifo_count, busy, frame_err, overrun}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      f0 = fe_cnt;
      out_ready = 1'b0;
      frame(tbl[i].bits, tbl[i].nb, 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_count", i), fifo_count, tbl[i].cnt);
      chk($sformatf("v%0d_head", i), out_data, tbl[i].head);
      chk($sformatf("v%0d_ferr", i), fe_cnt - f0, tbl[i].fe);
      chk($sformatf("v%0d_busy", i), busy, 0);
      drain();
    end

    // Overrun: five words into a four-deep FIFO
    o0 = ov_cnt;
    for (int v = 1; v <= 5; v++) frame(32'(v), 8, 1'b0, 1'b1);
    @(negedge clk);
    chk("ovr_count", fifo_count, 4);
    chk("ovr_pulses", ov_cnt - o0, 1);
    chk("ovr_head", out_data, 8'h01);
    drain();

    // Full FIFO, pop lands on the same cycle as the fifth write
    o0 = ov_cnt;
    for (int v = 1; v <= 4; v++) frame(32'(v), 8, 1'b0, 1'b1);
    w5 = 8'h05;
    @(posedge clk);
    #1 cs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) sbit(w5[7-i]);
    mosi = w5[0];
    repeat (4) @(posedge clk);
    #1 sclk = 1'b1;
    model_push(w5, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk) chk("simul_full_before", fifo_count, 4);
    @(negedge clk) chk("simul_count_kept", fifo_count, 4);
    @(posedge clk);
    #1 sclk = 1'b0;
    repeat (4) @(posedge clk);
    #1 cs = 1'b1;
    repeat (8) @(posedge clk);
    drain();
    chk("simul_no_ovr", ov_cnt - o0, 0);

    // Reset in the middle of a word with a word already queued
    f0 = fe_cnt;
    frame(32'h3C, 8, 1'b0, 1'b1);
    frame(32'hA, 4, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_outs",
        {out_valid, out_data, fifo_count, busy, frame_err, overrun}, 0);
    @(posedge clk);
    #1 cs = 1'b1;
    repeat (8) @(posedge clk);
    frame(32'hFF, 8, 1'b0, 1'b1);
    @(negedge clk);
    chk("after_reset_head", out_data, 8'hFF);
    chk("after_reset_count", fifo_count, 1);
    chk("after_reset_ferr", fe_cnt - f0, 0);
    drain();
    for (int i = 0; i < 8; i++) sbit(1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("cs_high_count", fifo_count, 0);
    chk("cs_high_busy", busy, 0);

    // Random frames, random consumer stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      frame($urandom, $urandom_range(1, 24), 1'b0, 1'b1);
    end
    rand_ready = 1'b0;
    drain();

    chk("total_ferr", fe_cnt, exp_fe);
    chk("total_ovr", ov_cnt, exp_ov);
    chk("ferr_width", fe_hi, fe_cnt);
    chk("ovr_width", ov_hi, ov_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
